// File: rtl/mnist_pkg.sv
// Shared defaults, the no-result digit code and the scheduler state encoding
// for the MNIST inference scheduler slice.
package mnist_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 16;
  localparam int IMG_W_DEF       = 4;

  localparam logic [3:0] NO_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ARGMAX,
    S_RESULT
  } sched_state_t;

endpackage

// File: rtl/inference_scheduler_if.sv
// Request, result and network-control signals of the inference scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface inference_scheduler_if
  import mnist_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
);

  logic                           req_valid;
  logic                           req_ready;
  logic [IMG_W-1:0]               req_img;
  logic                           res_valid;
  logic                           res_ready;
  logic [IMG_W-1:0]               res_img;
  logic [3:0]                     res_digit;
  logic [SCORE_W-1:0]             res_score;
  logic                           res_timeout;
  logic                           net_start;
  logic [IMG_W-1:0]               net_img_sel;
  logic                           net_done;
  logic [NUM_CLASSES*SCORE_W-1:0] net_scores;

  modport slave (
    input  req_valid, req_img, res_ready, net_done, net_scores,
    output req_ready, res_valid, res_img, res_digit, res_score, res_timeout,
           net_start, net_img_sel
  );

  modport master (
    output req_valid, req_img, res_ready, net_done, net_scores,
    input  req_ready, res_valid, res_img, res_digit, res_score, res_timeout,
           net_start, net_img_sel
  );

endinterface

// File: rtl/sched_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate flag.
module sched_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inference_scheduler.sv
// Queues classification requests, runs the network one image at a time under
// a watchdog, and reduces the returned scores to a winning digit.
module inference_scheduler
  import mnist_pkg::*;
#(
  parameter int QDEPTH      = 4,
  parameter int IMG_W       = IMG_W_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int TIMEOUT     = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  inference_scheduler_if.slave  bus,
  output logic                  busy
);

  localparam int IW   = $clog2(NUM_CLASSES + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int CW   = $clog2(QDEPTH) + 1;

  sched_state_t                   state;
  logic [WD_W-1:0]                wdog;
  logic [NUM_CLASSES*SCORE_W-1:0] scores_q;
  logic [IW-1:0]                  idx;
  logic [SCORE_W-1:0]             best_score;
  logic [3:0]                     best_idx;
  logic [SCORE_W-1:0]             cur_score;

  logic             fifo_pop;
  logic [IMG_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  sched_req_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (IMG_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .pop   (fifo_pop),
    .wdata (bus.req_img),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.req_ready = !fifo_full;
  assign fifo_pop      = (state == S_IDLE) && !fifo_empty;
  assign busy          = (state != S_IDLE) || (fifo_count != '0);

  // The captured scores shift down one class per ARGMAX cycle.
  assign cur_score = scores_q[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      wdog            <= '0;
      scores_q        <= '0;
      idx             <= '0;
      best_score      <= '0;
      best_idx        <= '0;
      bus.net_start   <= 1'b0;
      bus.net_img_sel <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_img     <= '0;
      bus.res_digit   <= '0;
      bus.res_score   <= '0;
      bus.res_timeout <= 1'b0;
    end else begin
      bus.net_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            bus.net_img_sel <= fifo_rdata;
            bus.net_start   <= 1'b1;
            state           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.net_done) begin
            scores_q <= bus.net_scores;
            idx      <= '0;
            state    <= S_ARGMAX;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            bus.res_valid   <= 1'b1;
            bus.res_timeout <= 1'b1;
            bus.res_digit   <= NO_DIGIT;
            bus.res_score   <= '0;
            bus.res_img     <= bus.net_img_sel;
            state           <= S_RESULT;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_ARGMAX: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (idx == IW'(NUM_CLASSES)) begin
            bus.res_valid   <= 1'b1;
            bus.res_timeout <= 1'b0;
            bus.res_digit   <= best_idx;
            bus.res_score   <= best_score;
            bus.res_img     <= bus.net_img_sel;
            state           <= S_RESULT;
          end else begin
            if ((idx == '0) || (cur_score > best_score)) begin
              best_score <= cur_score;
              best_idx   <= 4'(idx);
            end
            scores_q <= scores_q >> SCORE_W;
            idx      <= idx + IW'(1);
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inference_scheduler.sv
// Scenario bench for inference_scheduler: the bench plays the network and the
// result consumer, and scores results against a queue of expectations.
module tb_inference_scheduler;
  import mnist_pkg::*;

  localparam int IW  = 4;
  localparam int NC  = 10;
  localparam int SW  = 16;
  localparam int QD  = 4;
  localparam int TMO = 64;

  typedef struct packed {
    logic [IW-1:0] img;
    logic [3:0]    digit;
    logic [SW-1:0] score;
    logic          timeout;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;

  int   checks = 0;
  int   failures = 0;
  int   start_count = 0;
  exp_t sb[$];

  inference_scheduler_if #(.IMG_W(IW), .NUM_CLASSES(NC), .SCORE_W(SW)) bus ();

  inference_scheduler #(
    .QDEPTH      (QD),
    .IMG_W       (IW),
    .NUM_CLASSES (NC),
    .SCORE_W     (SW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.net_start === 1'b1) start_count++;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NC*SW-1:0] mk_scores(input int win, input logic [SW-1:0] win_val,
                                                 input logic [SW-1:0] base);
    logic [NC*SW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*SW +: SW] = (i == win) ? win_val : base;
    return v;
  endfunction

  function automatic int ref_argmax(input logic [NC*SW-1:0] v);
    int best = 0;
    for (int i = 1; i < NC; i++) if (v[i*SW +: SW] > v[best*SW +: SW]) best = i;
    return best;
  endfunction

  task automatic push_req(input logic [IW-1:0] img, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_img   = img;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (bus.net_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_res(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done(input logic [NC*SW-1:0] s);
    bus.net_scores = s;
    bus.net_done   = 1'b1;
    tick();
    bus.net_done   = 1'b0;
  endtask

  task automatic accept_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks++;
    if ({bus.req_ready, bus.res_valid, bus.res_timeout, bus.net_start, busy} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=10000",
               {bus.req_ready, bus.res_valid, bus.res_timeout, bus.net_start, busy});
    end
    checks++;
    if ({bus.res_digit, bus.res_score, bus.res_img, bus.net_img_sel} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_fields got=%h want=0",
               {bus.res_digit, bus.res_score, bus.res_img, bus.net_img_sel});
    end
    rst = 1'b1;
    tick(2);
    checks++;
    if ({bus.req_ready, busy, bus.net_start} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b want=100", {bus.req_ready, busy, bus.net_start});
    end
  endtask

  task automatic test_single();
    bit   ok;
    int   cyc;
    int   s0;
    exp_t e;
    s0 = start_count;
    sb.push_back('{img: 4'd3, digit: 4'd7, score: 16'h7F00, timeout: 1'b0});
    push_req(4'd3, ok);
    tick();
    checks++;
    if ({ok, bus.net_start, bus.net_img_sel} !== {1'b1, 1'b1, 4'd3}) begin
      failures++;
      $display("[TB] FAIL single_launch got=%b/%b/%0d want=1/1/3", ok, bus.net_start, bus.net_img_sel);
    end
    tick(3);
    pulse_done(mk_scores(7, 16'h7F00, 16'h0100));
    wait_res(ok, cyc);
    checks++;
    if (!ok || cyc != NC + 1) begin
      failures++;
      $display("[TB] FAIL single_latency got=%0d want=%0d (seen=%0d)", cyc, NC + 1, ok);
    end
    tick(2);
    e = sb.pop_front();
    checks++;
    if ({bus.res_valid, bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout} !== {1'b1, e}) begin
      failures++;
      $display("[TB] FAIL single_result got=%h want=%h",
               {bus.res_valid, bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout}, {1'b1, e});
    end
    accept_res();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_drop got=%b want=0", bus.res_valid);
    end
    checks++;
    if (start_count - s0 != 1) begin
      failures++;
      $display("[TB] FAIL single_start_count got=%0d want=1", start_count - s0);
    end
  endtask

  task automatic test_tie();
    bit               ok;
    int               cyc;
    exp_t             e;
    logic [NC*SW-1:0] v;
    v = mk_scores(2, 16'h4000, 16'h0100);
    v[5*SW +: SW] = 16'h4000;
    v[9*SW +: SW] = 16'h3FFF;
    sb.push_back('{img: 4'd5, digit: 4'd2, score: 16'h4000, timeout: 1'b0});
    push_req(4'd5, ok);
    wait_start(ok, cyc);
    tick(2);
    pulse_done(v);
    wait_res(ok, cyc);
    e = sb.pop_front();
    checks++;
    if (!ok || {bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout} !== e) begin
      failures++;
      $display("[TB] FAIL tie_result got=%h want=%h seen=%0d",
               {bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout}, e, ok);
    end
    accept_res();
  endtask

  task automatic test_argmax_sweep();
    bit               ok;
    int               cyc;
    int               d;
    exp_t             e;
    logic [NC*SW-1:0] v;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) v = mk_scores(0, 16'h1234, 16'h1234);
      else if (t == 1) v = mk_scores(9, 16'hFFFF, 16'h0100);
      else for (int i = 0; i < NC; i++) v[i*SW +: SW] = 16'($urandom_range(65535, 0));
      d = ref_argmax(v);
      sb.push_back('{img: 4'(8 + t), digit: 4'(d), score: v[d*SW +: SW], timeout: 1'b0});
      push_req(4'(8 + t), ok);
      wait_start(ok, cyc);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL sweep_start case=%0d got=none want=net_start", t);
      end
      tick(2);
      pulse_done(v);
      wait_res(ok, cyc);
      e = sb.pop_front();
      checks++;
      if (!ok || {bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout} !== e) begin
        failures++;
        $display("[TB] FAIL sweep_result case=%0d got=%h want=%h seen=%0d", t,
                 {bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout}, e, ok);
      end
      accept_res();
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    int   cyc;
    int   s0;
    exp_t e;
    s0 = start_count;
    for (int j = 0; j < 5; j++)
      sb.push_back('{img: 4'(j), digit: 4'((j + 3) % NC), score: 16'(16'h2000 + j), timeout: 1'b0});
    push_req(4'd0, ok);
    wait_start(ok, cyc);
    for (int j = 1; j < 5; j++) push_req(4'(j), ok);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_full got=%b want=0", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_img   = 4'd15;
    tick(3);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_full_hold got=%b want=0", bus.req_ready);
    end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        wait_start(ok, cyc);
        checks++;
        if (!ok || cyc != 1 || bus.net_img_sel !== 4'(j)) begin
          failures++;
          $display("[TB] FAIL b2b_launch job=%0d got=%0d cyc img=%0d want=1 cyc img=%0d",
                   j, cyc, bus.net_img_sel, j);
        end
      end
      tick(2);
      pulse_done(mk_scores((j + 3) % NC, 16'(16'h2000 + j), 16'h0100));
      wait_res(ok, cyc);
      tick(j % 3);
      e = sb.pop_front();
      checks++;
      if (!ok || {bus.res_valid, bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout} !== {1'b1, e}) begin
        failures++;
        $display("[TB] FAIL b2b_result job=%0d got=%h want=%h", j,
                 {bus.res_valid, bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout}, {1'b1, e});
      end
      accept_res();
    end
    tick(10);
    checks++;
    if ({bus.res_valid, busy, bus.req_ready} !== 3'b001 || start_count - s0 != 5) begin
      failures++;
      $display("[TB] FAIL b2b_drain got=%b starts=%0d want=001 starts=5",
               {bus.res_valid, busy, bus.req_ready}, start_count - s0);
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    int   cyc;
    bit   seen;
    exp_t e;
    sb.push_back('{img: 4'd6, digit: NO_DIGIT, score: 16'h0000, timeout: 1'b1});
    push_req(4'd6, ok);
    wait_start(ok, cyc);
    wait_res(ok, cyc);
    checks++;
    if (!ok || cyc != TMO + 1) begin
      failures++;
      $display("[TB] FAIL timeout_latency got=%0d want=%0d (seen=%0d)", cyc, TMO + 1, ok);
    end
    e = sb.pop_front();
    checks++;
    if ({bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout} !== e) begin
      failures++;
      $display("[TB] FAIL timeout_result got=%h want=%h",
               {bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout}, e);
    end
    pulse_done(mk_scores(1, 16'hFFFF, 16'h0000));
    checks++;
    if ({bus.res_valid, bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout} !== {1'b1, e}) begin
      failures++;
      $display("[TB] FAIL timeout_late_done got=%h want=%h",
               {bus.res_valid, bus.res_img, bus.res_digit, bus.res_score, bus.res_timeout}, {1'b1, e});
    end
    accept_res();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.res_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_no_second got=activity want=idle");
    end
  endtask

  task automatic test_done_in_idle();
    bit seen;
    int s0;
    s0 = start_count;
    seen = 1'b0;
    pulse_done(mk_scores(4, 16'h7777, 16'h0001));
    for (int i = 0; i < 15; i++) begin
      if (bus.res_valid || busy) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || start_count != s0) begin
      failures++;
      $display("[TB] FAIL idle_done got=seen%0d starts%0d want=seen0 starts0", seen, start_count - s0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    push_req(4'd1, ok);
    push_req(4'd2, ok);
    push_req(4'd3, ok);
    pulse_done(mk_scores(3, 16'h5000, 16'h0010));
    tick(3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_busy_before got=%b want=1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.res_valid, bus.res_timeout, bus.net_start, busy} !== 5'b10000 ||
        {bus.res_digit, bus.res_score, bus.res_img, bus.net_img_sel} !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_values got=%b/%h want=10000/0",
               {bus.req_ready, bus.res_valid, bus.res_timeout, bus.net_start, busy},
               {bus.res_digit, bus.res_score, bus.res_img, bus.net_img_sel});
    end
    tick(2);
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_busy_after got=%b want=0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.res_valid || bus.net_start) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_quiet got=activity want=none");
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_img    = '0;
    bus.res_ready  = 1'b0;
    bus.net_done   = 1'b0;
    bus.net_scores = '0;
    #2;
    test_reset();
    test_single();
    test_tie();
    test_argmax_sweep();
    test_back_to_back();
    test_timeout();
    test_done_in_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inference_scheduler.md
# inference_scheduler

Queues image-classification requests, sequences the MNIST network one image at a time, and reduces the ten 16-bit softmax scores to a winning digit. It sits above the network top level. It drives the network's start pulse and image-bank select, waits for the network's done signal under a watchdog, and returns each result through a valid/ready handshake.

## Interface
- `QDEPTH`, 4: request FIFO depth (power of two, ≥2)
- `IMG_W`, 4: image-index width (selects ROM bank)
- `NUM_CLASSES`, 10: number of scores
- `SCORE_W`, 16: width of one score
- `TIMEOUT`, 8192: maximum cycles in WAIT before abort

One clock; reset is asynchronous and active-low.

- `clk` in 1: clock
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: FIFO not full
- `req_img` in IMG_W: image index to classify
- `res_valid` out 1: result present
- `res_ready` in 1: consumer accepts result
- `res_img` out IMG_W: image index of the result
- `res_digit` out 4: winning class, 4'hF on timeout
- `res_score` out SCORE_W: winning score, 0 on timeout
- `res_timeout` out 1: result was aborted by the watchdog
- `net_start` out 1: one-cycle network start pulse
- `net_img_sel` out IMG_W: image bank for the running inference
- `net_done` in 1: network finished (one-cycle pulse)
- `net_scores` in NUM_CLASSES*SCORE_W: class i is at [i*SCORE_W +: SCORE_W]
- `busy` out 1: FSM is not in IDLE, or the FIFO is not empty

## Operation
- Request FIFO:
  - Push on `req_valid && req_ready`; `req_ready = !full`.
  - Pop on the IDLE→LAUNCH transition.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- FSM states: IDLE, LAUNCH, WAIT, ARGMAX, RESULT.
  - IDLE: if the FIFO is not empty, pop it, latch `net_img_sel`, and go to LAUNCH.
  - LAUNCH: `net_start`=1 for this single cycle; clear the watchdog; go to WAIT.
  - WAIT: the watchdog counts up.
    - On `net_done`: capture `net_scores` into a register and go to ARGMAX.
    - Else if the watchdog reaches TIMEOUT-1: set `res_timeout`=1, `res_digit`=4'hF, `res_score`=0, and go to RESULT.
  - ARGMAX: one class per cycle, index 0..NUM_CLASSES-1.
    - Comparison is unsigned. Replace the best only on strictly greater, so ties go to the lowest index.
    - Class 0 initialises the best.
    - Go to RESULT after class NUM_CLASSES-1.
  - RESULT: `res_valid`=1 with all `res_*` fields held stable. On `res_ready`, go to IDLE.
- `net_done` outside WAIT is ignored. A `net_done` arriving after a timeout does not create a second result.
- `net_img_sel` holds its value from LAUNCH until the next LAUNCH.
- Reset mid-operation: the FIFO is emptied, the FSM goes to IDLE, and no result is emitted for in-flight work.

## Timing
- Reset values:
  - `req_ready`=1
  - `res_valid`=0, `res_timeout`=0, `res_digit`=0, `res_score`=0, `res_img`=0
  - `net_start`=0, `net_img_sel`=0, `busy`=0
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output except `req_ready` (FIFO count only).
- Launch latency: if a request is accepted at edge k with the scheduler idle and the FIFO empty, `net_start` is high during the cycle following edge k+1.
- Result latency: `net_done` sampled at edge d gives `res_valid` high after edge d+NUM_CLASSES+1 (11 cycles by default).
- Timeout: `res_valid` rises TIMEOUT+1 cycles after `net_start`.
- Back-to-back: after `res_ready` is accepted at edge r with the FIFO not empty, `net_start` is high during the cycle following edge r+1.

## Structure
- Package `mnist_pkg` holds:
  - NUM_CLASSES, SCORE_W, IMG_W defaults
  - NO_DIGIT = 4'hF
  - the FSM state enum
- Sub-module `sched_req_fifo`: synchronous FIFO with pointers of log2(QDEPTH)+1 bits, plus full/empty and a count output.

## Test plan
- Single request, img=3; the network returns scores with class 7 = 16'h7F00 and all others 16'h0100. Required: `net_img_sel`=3, exactly one `net_start`, result digit=7, score=16'h7F00, timeout=0, 11 cycles after `net_done`.
- Tie: classes 2 and 5 both 16'h4000, all others lower. Required: digit=2.
- Push 5 requests back-to-back with QDEPTH=4 while the first inference is in WAIT. Required: `req_ready` drops after the 4th FIFO entry. Results come out in order 0..4, `res_ready` stalls are held, and there is no duplicate or lost result.
- `net_done` withheld with TIMEOUT=64. Required: digit=4'hF, score=0, timeout=1, `res_valid` 65 cycles after `net_start`. A later `net_done` is ignored.
- `rst` asserted during ARGMAX with 2 requests queued. Required: all reset values immediately, `busy`=0 after release, and no `res_valid`.
- `net_done` pulsed in IDLE. Required: no state change, no result.
